// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and helpers for the MULT/DIV sequencer.
package multdiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/multdiv_seq_div_step.sv
// One iteration of unsigned restoring division: shift the next dividend bit
// into the partial remainder, keep the trial difference only if it is
// non-negative, and shift the resulting quotient bit in.
module div_step
    import multdiv_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;
    logic            fits;

    // Trial subtract; a failed trial restores by keeping the shifted remainder.
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        fits     = (shifted >= {1'b0, dvs});
        rem_next = fits ? DATA_W'(shifted - {1'b0, dvs}) : shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/multdiv_seq.sv
// Sequencer and datapath for the MULT/DIV unit feeding HI/LO.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start_mult / start_div
//   MULT  | radix-2 Booth, one iteration per clock, ITER iterations
//   DIV   | restoring division on magnitudes, ITER iterations
//   DONE  | done (and div_zero if applicable) for one cycle
//
// acc/q/m are shared: in MULT they are Booth upper half / multiplier /
// multiplicand, in DIV partial remainder / dividend-then-quotient / divisor.
module multdiv_seq
    import multdiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_MULT = 2'(MULT);
    localparam logic [1:0] S_DIV  = 2'(DIV);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] m;
    logic              q_m1;
    logic              neg_q;
    logic              neg_r;
    logic              dz;

    logic [DATA_W:0]   booth_sum;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic              last;

    // Booth add/subtract on a sign-extended upper half so -2^31 * -2^31 stays exact.
    always_comb begin
        case ({q[0], q_m1})
            2'b01:   booth_sum = {acc[DATA_W-1], acc} + {m[DATA_W-1], m};
            2'b10:   booth_sum = {acc[DATA_W-1], acc} - {m[DATA_W-1], m};
            default: booth_sum = {acc[DATA_W-1], acc};
        endcase
    end

    div_step u_div_step (
        .rem      (acc),
        .quo      (q),
        .dvs      (m),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign last     = (cnt == CNT_W'(ITER - 1));
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign div_zero = dz;

    // Sequencer, iteration registers and HI/LO result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            q_m1   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_mult) begin
                        acc   <= '0;
                        q     <= op_b;
                        q_m1  <= 1'b0;
                        m     <= op_a;
                        state <= S_MULT;
                    end else if (start_div) begin
                        if (op_b == '0) begin
                            // HI/LO deliberately untouched; only the flag is raised.
                            dz    <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            acc   <= '0;
                            q     <= mag(op_a);
                            m     <= mag(op_b);
                            neg_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                            neg_r <= op_a[DATA_W-1];
                            state <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc  <= booth_sum[DATA_W:1];
                    q    <= {booth_sum[0], q[DATA_W-1:1]};
                    q_m1 <= q[0];
                    if (last) begin
                        hi_out <= booth_sum[DATA_W:1];
                        lo_out <= {booth_sum[0], q[DATA_W-1:1]};
                        cnt    <= '0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    acc <= rem_next;
                    q   <= quo_next;
                    if (last) begin
                        lo_out <= neg_q ? -quo_next : quo_next;
                        hi_out <= neg_r ? -rem_next : rem_next;
                        cnt    <= '0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    dz    <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: hand-computed products/quotients, timing,
// handshake corner cases and mid-operation reset.
module tb_multdiv_seq;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_total = 0;
    int n_pass  = 0;

    multdiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Issue one start pulse sampled at edge E0, then track the operation to done.
    // inj_cyc > 0 drives an extra start pulse in that cycle (counted from E0).
    task automatic run_op(input string tag, input logic m_s, input logic d_s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_cyc,
                          input int inj_cyc, input logic inj_m, input logic inj_d);
        int   cyc;
        int   bcnt;
        logic seen;
        logic dz_at_done;
        @(posedge clk); #1;
        start_mult = m_s; start_div = d_s; op_a = a; op_b = b;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0;
        cyc = 0; bcnt = 0; seen = 1'b0; dz_at_done = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            start_mult = 1'b0; start_div = 1'b0;
            cyc++;
            if (busy) bcnt++;
            if (cyc == inj_cyc) begin
                start_mult = inj_m; start_div = inj_d; op_b = 32'h0;
            end
            if (done) begin
                seen = 1'b1;
                dz_at_done = div_zero;
            end
        end
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " busy_cycles"}, bcnt, exp_cyc);
        check({tag, " hi"}, hi_out, exp_hi);
        check({tag, " lo"}, lo_out, exp_lo);
        check({tag, " div_zero"}, {31'b0, dz_at_done}, {31'b0, exp_dz});
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0;
        check({tag, " done_one_cycle"}, {31'b0, done}, 32'h0);
        check({tag, " idle_after"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int nd;
        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0;
        op_a = '0; op_b = '0;
        #12;
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst done", {31'b0, done}, 32'h0);
        check("rst div_zero", {31'b0, div_zero}, 32'h0);
        check("rst hi", hi_out, 32'h0);
        check("rst lo", lo_out, 32'h0);
        @(negedge clk); reset = 1'b1;

        run_op("mul 7*-3",      1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33, 0, 0, 0);
        run_op("div -7/2",      0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33, 0, 0, 0);
        run_op("div 5/0",       0, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1, 0, 0, 0);
        run_op("div 100/7",     0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 33, 0, 0, 0);
        run_op("div 7/-2",      0, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 33, 0, 0, 0);
        run_op("mul min*min",   1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 33, 0, 0, 0);
        run_op("div min/-1",    0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 33, 0, 0, 0);
        run_op("mul 0*-1",      1, 0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 33, 0, 0, 0);
        run_op("mul div_ignored", 1, 0, 32'd3, 32'd5, 32'h0, 32'd15, 0, 33, 5, 0, 1);
        run_op("both starts",   1, 1, 32'd6, 32'd7, 32'h0, 32'd42, 0, 33, 0, 0, 0);
        run_op("start in DONE", 1, 0, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 33, 1, 0);

        // Reset in the middle of a division: outputs clear before any clock edge.
        @(posedge clk); #1;
        start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start_div = 1'b0;
        repeat (11) @(negedge clk);
        check("pre-reset busy", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("async rst busy", {31'b0, busy}, 32'h0);
        check("async rst done", {31'b0, done}, 32'h0);
        check("async rst hi", hi_out, 32'h0);
        check("async rst lo", lo_out, 32'h0);
        @(negedge clk); reset = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("no done after abort", nd, 0);

        run_op("mul 6*7 after rst", 1, 0, 32'd6, 32'd7, 32'h0, 32'd42, 0, 33, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Sequencer and datapath for the MULT/DIV resource that feeds the HI/LO registers in the multicycle CPU.
- ctrl_unit issues a one-cycle start. It then stalls while busy is high and resumes on done.
- div_zero is routed to ctrl_unit's exception path. A divide-by-zero completes immediately and leaves HI/LO unchanged.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- ITER, 32, iterations per operation (equals DATA_W).
- CNT_W, 6, iteration counter width (must hold ITER).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start_mult  in  1  one-cycle request: signed op_a*op_b.
- start_div  in  1  one-cycle request: signed op_a/op_b.
- op_a  in  DATA_W  multiplicand / dividend (register A value).
- op_b  in  DATA_W  multiplier / divisor (register B value).
- busy  out  1  high whenever state != IDLE.
- done  out  1  high for exactly one cycle; result valid on hi_out/lo_out.
- div_zero  out  1  high together with done when a division had op_b == 0.
- hi_out  out  DATA_W  MULT: product[63:32]; DIV: remainder.
- lo_out  out  DATA_W  MULT: product[31:0]; DIV: quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0. A reset mid-operation aborts immediately; no done is issued.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - start_mult sampled at edge E0: latch operands, clear accumulator, cnt=0, go to MULT.
  - start_div with op_b != 0: latch |op_a|, |op_b| and both sign bits, go to DIV.
  - start_div with op_b == 0: go directly to DONE, set div_zero=1; HI/LO are not written.
  - Both starts high: start_mult wins; start_div is dropped.
- Starts asserted while busy=1 are ignored; no queuing.
- MULT, radix-2 Booth:
  - One iteration per edge: inspect {Q[0], q_-1}, add, subtract or do nothing on the upper half, then arithmetic shift right.
  - The add/subtract path is DATA_W+1 bits wide so that -2^31 * -2^31 is exact.
  - After the ITER-th iteration (edge E32), write hi_out/lo_out and go to DONE.
- DIV, unsigned restoring division on magnitudes:
  - One iteration per edge: shift remainder/quotient left, trial-subtract the divisor magnitude, restore if negative.
  - At edge E32, apply sign fixups and write the outputs, then go to DONE.
  - Sign rules: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - Results are truncated to DATA_W. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DONE: done=1, plus div_zero if applicable, for one cycle. Next edge goes to IDLE. A start arriving during DONE is ignored.
- Timing:
  - Normal operation: done is high in the cycle after E32, and busy is high from after E0 through the DONE cycle. Total is 33 busy cycles.
  - Divide-by-zero: done and div_zero are high in the cycle after E0.
- hi_out/lo_out are registers. They hold their value until the next successful completion and never show intermediate values.
- cnt counts 0..ITER-1; the terminal test is cnt == ITER-1. There is no wrap-around.

Decomposition:
- Package multdiv_pkg:
  - state enum {IDLE, MULT, DIV, DONE};
  - DATA_W, ITER and CNT_W constants;
  - a function for two's-complement magnitude.
- One sub-module, div_step: combinational restoring step (remainder, quotient, divisor -> next remainder, next quotient). The Booth step stays inline.
- ctrl_unit consumes busy, done and div_zero. No other new shared types.

Test Plan:
- start_mult, op_a=7, op_b=0xFFFFFFFD (-3) -> done exactly 33 cycles after the start edge; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for 33 cycles.
- start_div, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1), div_zero=0.
- Preload HI/LO with the previous result, then start_div, op_a=5, op_b=0 -> done=div_zero=1 one cycle later; hi_out/lo_out unchanged; busy high for 1 cycle.
- Corners:
  - 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - 0 * 0xFFFFFFFF -> hi=lo=0.
- Handshake:
  - start_div pulsed during MULT -> ignored; the MULT result is correct.
  - start_mult and start_div together -> MULT executes.
  - start pulsed during DONE -> ignored.
- Pull reset low at DIV iteration 10 -> busy=0, hi_out=lo_out=0 without waiting for a clock; no done. A following start_mult 6*7 -> lo=42, hi=0.
